// File: rtl/id_decode_stage_pkg.sv
// Shared decode constants for the RV64I ID stage:
// opcodes, funct3 values, ALU op codes and the control bundle.
package id_decode_stage_pkg;

  localparam int XLEN_D  = 64;
  localparam int NREGS_D = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic beq;
    logic bne;
    logic jal;
    logic jalr;
  } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// 32x64 integer register file, 2R/1W, async active-low clear,
// x0 hardwired to zero, write-through bypass on both read ports.
module id_regfile
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            we,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // WB result is forwarded so ID sees it in the same cycle
  always_comb begin
    rd1 = '0;
    if (ra1 != 5'd0) begin
      rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != 5'd0) begin
      rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
    end
  end

endmodule

// File: rtl/id_decode_stage.sv
// RV64I instruction-decode stage: register file, main control
// decoder, ALU-op decoder and immediate generator.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_D,
  input  logic [63:0]     PC_D,
  input  logic [XLEN-1:0] write_data,
  input  logic [4:0]      write_reg,
  input  logic            reg_write,
  output logic [XLEN-1:0] data_rs1,
  output logic [XLEN-1:0] data_rs2,
  output logic [XLEN-1:0] imm_val,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      ALUop,
  output logic            MemReadEn,
  output logic            MemToReg,
  output logic            MemWriteEn,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            BEQ,
  output logic            BNE,
  output logic            JALen,
  output logic            JALRen
);

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  alu_op_e         arith_op;
  alu_op_e         alu_op;
  ctrl_t           ctrl;
  logic            pc_unused;

  assign ins    = instruction_D;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign f7b5   = ins[30];

  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  assign pc_unused = ^PC_D;

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1),
    .ra2   (rs2),
    .wa    (write_reg),
    .wd    (write_data),
    .we    (reg_write),
    .rd1   (data_rs1),
    .rd2   (data_rs2)
  );

  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  // Immediate forms never produce SUB; shifts keep SRA via funct7[5]
  always_comb begin
    arith_op = ALU_ADD;
    unique case (funct3)
      F3_ADD: begin
        if (f7b5 && (opcode == OPC_OP || opcode == OPC_OP32))
          arith_op = ALU_SUB;
        else
          arith_op = ALU_ADD;
      end
      F3_SLL:  arith_op = ALU_SLL;
      F3_SLT:  arith_op = ALU_SLT;
      F3_SLTU: arith_op = ALU_SLTU;
      F3_XOR:  arith_op = ALU_XOR;
      F3_SR:   arith_op = f7b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   arith_op = ALU_OR;
      F3_AND:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    alu_op  = ALU_ADD;
    imm_val = '0;
    unique case (1'b1)
      (opcode == OPC_OP),
      (opcode == OPC_OP32): begin
        ctrl.reg_write = 1'b1;
        alu_op         = arith_op;
      end
      (opcode == OPC_OPIMM),
      (opcode == OPC_OPIMM32): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = arith_op;
        imm_val        = imm_i;
      end
      (opcode == OPC_LOAD): begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        imm_val         = imm_i;
      end
      (opcode == OPC_STORE): begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        imm_val        = imm_s;
      end
      (opcode == OPC_BRANCH): begin
        ctrl.beq = (funct3 == F3_BEQ);
        ctrl.bne = (funct3 == F3_BNE);
        alu_op   = ALU_SUB;
        imm_val  = imm_b;
      end
      (opcode == OPC_LUI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = ALU_PASSB;
        imm_val        = imm_u;
      end
      (opcode == OPC_JAL): begin
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        imm_val        = imm_j;
      end
      (opcode == OPC_JALR): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.jalr      = 1'b1;
        imm_val        = imm_i;
      end
      default: begin
        ctrl    = '0;
        alu_op  = ALU_ADD;
        imm_val = '0;
      end
    endcase
  end

  assign ALUop      = alu_op;
  assign MemReadEn  = ctrl.mem_read;
  assign MemToReg   = ctrl.mem_to_reg;
  assign MemWriteEn = ctrl.mem_write;
  assign ALUSrc     = ctrl.alu_src;
  assign RegWrite   = ctrl.reg_write;
  assign BEQ        = ctrl.beq;
  assign BNE        = ctrl.bne;
  assign JALen      = ctrl.jal;
  assign JALRen     = ctrl.jalr;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed vectors plus
// randomized decode and register-file traffic against a reference model.
module tb_id_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instruction_D;
  logic [63:0] PC_D;
  logic [63:0] write_data;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic [63:0] data_rs1, data_rs2, imm_val;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  ALUop;
  logic        MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite;
  logic        BEQ, BNE, JALen, JALRen;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] rf_model [32];

  typedef struct packed {
    logic [3:0]  aluop;
    logic [8:0]  ctl;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dec_t;

  // funct3 -> ALU code: ADD SLL SLT SLTU XOR SRL OR AND
  logic [3:0] f3_tbl [8] = '{4'd0, 4'd5, 4'd8, 4'd9,
                             4'd4, 4'd6, 4'd3, 4'd2};

  id_decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .instruction_D (instruction_D),
    .PC_D          (PC_D),
    .write_data    (write_data),
    .write_reg     (write_reg),
    .reg_write     (reg_write),
    .data_rs1      (data_rs1),
    .data_rs2      (data_rs2),
    .imm_val       (imm_val),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .ALUop         (ALUop),
    .MemReadEn     (MemReadEn),
    .MemToReg      (MemToReg),
    .MemWriteEn    (MemWriteEn),
    .ALUSrc        (ALUSrc),
    .RegWrite      (RegWrite),
    .BEQ           (BEQ),
    .BNE           (BNE),
    .JALen         (JALen),
    .JALRen        (JALRen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_ins(input logic [4:0] a,
                                         input logic [4:0] b);
    return {7'd0, b, a, 3'd0, 5'd0, 7'b0110011};
  endfunction

  function automatic dec_t dut_view();
    dec_t d;
    d.aluop = ALUop;
    d.ctl   = {MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite,
               BEQ, BNE, JALen, JALRen};
    d.imm   = imm_val;
    d.rs1   = rs1;
    d.rs2   = rs2;
    d.rd    = rd;
    return d;
  endfunction

  // ctl bits: {mr, m2r, mw, src, rw, beq, bne, jal, jalr}
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t        e;
    logic [2:0]  f3;
    logic [63:0] im_i, im_s, im_b, im_u, im_j;
    e     = '0;
    f3    = i[14:12];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    im_i  = 64'($signed(i[31:20]));
    im_s  = 64'($signed({i[31:25], i[11:7]}));
    im_b  = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    im_u  = 64'($signed({i[31:12], 12'd0}));
    im_j  = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    case (i[6:0])
      7'h33, 7'h3B: begin
        e.ctl   = 9'b000010000;
        e.aluop = f3_tbl[f3];
        if ((f3 == 3'd0 || f3 == 3'd5) && i[30]) e.aluop += 4'd1;
      end
      7'h13, 7'h1B: begin
        e.ctl   = 9'b000110000;
        e.aluop = f3_tbl[f3];
        if (f3 == 3'd5 && i[30]) e.aluop = 4'd7;
        e.imm   = im_i;
      end
      7'h03: begin e.ctl = 9'b110110000; e.imm = im_i; end
      7'h23: begin e.ctl = 9'b001100000; e.imm = im_s; end
      7'h63: begin
        e.aluop = 4'd1;
        e.imm   = im_b;
        if (f3 == 3'd0) e.ctl = 9'b000001000;
        if (f3 == 3'd1) e.ctl = 9'b000000100;
      end
      7'h37: begin e.ctl = 9'b000110000; e.aluop = 4'd10; e.imm = im_u; end
      7'h6F: begin e.ctl = 9'b000010010; e.imm = im_j; end
      7'h67: begin e.ctl = 9'b000110001; e.imm = im_i; end
      default: begin e.ctl = '0; e.aluop = 4'd0; e.imm = '0; end
    endcase
    return e;
  endfunction

  task automatic test_reset();
    reset         = 1'b0;
    reg_write     = 1'b0;
    write_reg     = '0;
    write_data    = '0;
    PC_D          = 64'h8000_0000;
    instruction_D = '0;
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    #12;
    reset = 1'b1;
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      instruction_D = rd_ins(5'(r), 5'(r));
      #1;
      n_tests++;
      if (data_rs1 !== 64'd0 || data_rs2 !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_x%0d: rs1=%h rs2=%h want 0", r,
                 data_rs1, data_rs2);
      end
    end
  endtask

  task automatic test_regwrite();
    logic [63:0] v;
    v = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    instruction_D = rd_ins(5'd5, 5'd0);
    write_reg = 5'd5; write_data = v; reg_write = 1'b1;
    #1;
    n_tests++;
    if (data_rs1 !== v) begin
      n_fail++;
      $display("FAIL bypass_x5: got %h want %h", data_rs1, v);
    end
    @(negedge clk);
    reg_write = 1'b0; write_data = '0;
    #1;
    n_tests++;
    if (data_rs1 !== v) begin
      n_fail++;
      $display("FAIL stored_x5: got %h want %h", data_rs1, v);
    end
    @(negedge clk);
    instruction_D = rd_ins(5'd0, 5'd0);
    write_reg = 5'd0; write_data = 64'hFFFF_0000_FFFF_0000;
    reg_write = 1'b1;
    #1;
    n_tests++;
    if (data_rs1 !== 64'd0 || data_rs2 !== 64'd0) begin
      n_fail++;
      $display("FAIL x0_bypass: rs1=%h rs2=%h want 0", data_rs1, data_rs2);
    end
    @(negedge clk);
    reg_write = 1'b0;
    #1;
    n_tests++;
    if (data_rs1 !== 64'd0) begin
      n_fail++;
      $display("FAIL x0_write: got %h want 0", data_rs1);
    end
    // asynchronous clear mid-cycle
    instruction_D = rd_ins(5'd5, 5'd5);
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (data_rs1 !== 64'd0 || data_rs2 !== 64'd0) begin
      n_fail++;
      $display("FAIL async_clear: rs1=%h rs2=%h want 0",
               data_rs1, data_rs2);
    end
    reset = 1'b1;
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
  endtask

  task automatic test_directed();
    logic [31:0] ins [12];
    dec_t        exp [12];
    dec_t        got;
    ins[0]  = 32'h002081B3; exp[0]  = {4'd0, 9'b000010000, 64'd0, 5'd1, 5'd2, 5'd3};
    ins[1]  = 32'h01000093; exp[1]  = {4'd0, 9'b000110000, 64'd16, 5'd0, 5'd16, 5'd1};
    ins[2]  = 32'h0011A023; exp[2]  = {4'd0, 9'b001100000, 64'd0, 5'd3, 5'd1, 5'd0};
    ins[3]  = 32'h0000B103; exp[3]  = {4'd0, 9'b110110000, 64'd0, 5'd1, 5'd0, 5'd2};
    ins[4]  = 32'h02018063; exp[4]  = {4'd1, 9'b000001000, 64'd32, 5'd3, 5'd0, 5'd0};
    ins[5]  = 32'hFE009EE3; exp[5]  = {4'd1, 9'b000000100, 64'hFFFF_FFFF_FFFF_FFFC,
                                       5'd1, 5'd0, 5'd29};
    ins[6]  = 32'h000010B7; exp[6]  = {4'd10, 9'b000110000, 64'h1000, 5'd0, 5'd0, 5'd1};
    ins[7]  = 32'h0010006F; exp[7]  = {4'd0, 9'b000010010, 64'd2048, 5'd0, 5'd1, 5'd0};
    ins[8]  = 32'h000080E7; exp[8]  = {4'd0, 9'b000110001, 64'd0, 5'd1, 5'd0, 5'd1};
    ins[9]  = 32'h40208133; exp[9]  = {4'd1, 9'b000010000, 64'd0, 5'd1, 5'd2, 5'd2};
    ins[10] = 32'h4030D093; exp[10] = {4'd7, 9'b000110000, 64'd1027, 5'd1, 5'd3, 5'd1};
    ins[11] = 32'h00000000; exp[11] = {4'd0, 9'b000000000, 64'd0, 5'd0, 5'd0, 5'd0};
    reg_write = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      instruction_D = ins[k];
      #1;
      got = dut_view();
      n_tests++;
      if (got !== exp[k]) begin
        n_fail++;
        $display("FAIL dir_%0d ins=%h: got alu=%h ctl=%b imm=%h rs=%0d/%0d rd=%0d want alu=%h ctl=%b imm=%h rs=%0d/%0d rd=%0d",
                 k, ins[k], got.aluop, got.ctl, got.imm, got.rs1, got.rs2,
                 got.rd, exp[k].aluop, exp[k].ctl, exp[k].imm,
                 exp[k].rs1, exp[k].rs2, exp[k].rd);
      end
    end
  endtask

  task automatic test_random_decode();
    logic [6:0]  opcs [11];
    logic [31:0] i;
    dec_t        e, got;
    opcs = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23,
             7'h63, 7'h37, 7'h6F, 7'h67, 7'h00};
    for (int k = 0; k < 400; k++) begin
      i = $urandom;
      if ($urandom_range(0, 9) != 0)
        i[6:0] = opcs[$urandom_range(0, 10)];
      @(negedge clk);
      instruction_D = i;
      PC_D = {$urandom, $urandom};
      #1;
      e   = ref_decode(i);
      got = dut_view();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rand_dec ins=%h: got alu=%h ctl=%b imm=%h want alu=%h ctl=%b imm=%h",
                 i, got.aluop, got.ctl, got.imm, e.aluop, e.ctl, e.imm);
      end
    end
  endtask

  task automatic test_random_regfile();
    logic [4:0]  a, b, w;
    logic [63:0] d, ea, eb;
    logic        we;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      a  = 5'($urandom_range(0, 31));
      b  = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      w  = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      we = ($urandom_range(0, 3) != 0);
      instruction_D = rd_ins(a, b);
      write_reg = w; write_data = d; reg_write = we;
      #1;
      ea = (a == 0) ? 64'd0 : (we && w == a) ? d : rf_model[a];
      eb = (b == 0) ? 64'd0 : (we && w == b) ? d : rf_model[b];
      n_tests++;
      if (data_rs1 !== ea || data_rs2 !== eb) begin
        n_fail++;
        $display("FAIL rand_rf a=%0d b=%0d: got %h/%h want %h/%h",
                 a, b, data_rs1, data_rs2, ea, eb);
      end
      @(posedge clk);
      if (we && w != 0) rf_model[w] = d;
    end
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [4];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v[k] = {$urandom, $urandom};
      write_reg = 5'(28 + k); write_data = v[k]; reg_write = 1'b1;
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int k = 0; k < 4; k += 2) begin
      @(negedge clk);
      instruction_D = rd_ins(5'(28 + k), 5'(29 + k));
      #1;
      n_tests++;
      if (data_rs1 !== v[k] || data_rs2 !== v[k+1]) begin
        n_fail++;
        $display("FAIL b2b_x%0d: got %h/%h want %h/%h", 28 + k,
                 data_rs1, data_rs2, v[k], v[k+1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_regwrite();
    test_directed();
    test_random_decode();
    test_random_regfile();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
